// File: rtl/sub_share_arbiter.sv
// Two-requester front end for one shared 64-bit subtractor: burst-limited round-robin
// grant, operand capture, one-cycle compute, registered valid/ready result.
// Optional build macro SUB_ARB_FLAGS_EN adds the {N,Z,C,V} result flags.

module Sixty_Four_Bit_Subtractor (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        carry_in,
  output logic [63:0] diff,
  output logic        borrow_out
);

  // carry_in acts as a borrow-in; borrow_out is set when a < b + carry_in.
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {64'd0, carry_in};

endmodule

module sub_share_arbiter #(
  parameter logic FIRST_PRI = 1'b0,
  parameter int   BURST_LEN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_diff,
  output logic [3:0]  rsp_flags,
  output logic        busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        op_a_q, op_a_d;
  logic [63:0]        op_b_q, op_b_d;
  logic               op_id_q, op_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [63:0]        rsp_diff_q, rsp_diff_d;
  logic               pri_q, pri_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_g_q, last_g_d;

  logic               in_idle;
  logic               any_valid;
  logic               grant_id;
  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic [63:0]        sub_diff;
  logic               sub_borrow;

  Sixty_Four_Bit_Subtractor u_sub (
    .a          (op_a_q),
    .b          (op_b_q),
    .carry_in   (1'b0),
    .diff       (sub_diff),
    .borrow_out (sub_borrow)
  );

  // Readies are held low while reset is asserted so nothing is accepted on a reset edge.
  always_comb begin
    in_idle   = (state_q == IDLE) && !reset;
    any_valid = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? pri_q : req1_valid;
    accept    = in_idle && any_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    busy       = (state_q != IDLE);
  end

  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_diff_d  = rsp_diff_q;
    if (accept) begin
      op_a_d  = grant_id ? req1_a : req0_a;
      op_b_d  = grant_id ? req1_b : req0_b;
      op_id_d = grant_id;
    end
    if (state_q == CALC) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = op_id_q;
      rsp_diff_d  = sub_diff;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // A requester keeps priority until it has won BURST_LEN times in a row.
  always_comb begin
    pri_d    = pri_q;
    cnt_d    = cnt_q;
    last_g_d = last_g_q;
    cnt_inc  = (grant_id == last_g_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    if (accept) begin
      last_g_d = grant_id;
      if (cnt_inc == CNT_W'(BURST_LEN)) begin
        pri_d = ~grant_id;
        cnt_d = '0;
      end else begin
        pri_d = grant_id;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_diff_q  <= '0;
      pri_q       <= FIRST_PRI;
      cnt_q       <= '0;
      last_g_q    <= FIRST_PRI;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_diff_q  <= rsp_diff_d;
      pri_q       <= pri_d;
      cnt_q       <= cnt_d;
      last_g_q    <= last_g_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_diff  = rsp_diff_q;

`ifdef SUB_ARB_FLAGS_EN
  logic [3:0] rsp_flags_q, rsp_flags_d;

  // C is the inverse of the subtractor borrow; V is signed overflow of a - b.
  always_comb begin
    rsp_flags_d = rsp_flags_q;
    if (state_q == CALC) begin
      rsp_flags_d = {sub_diff[63],
                     (sub_diff == 64'd0),
                     ~sub_borrow,
                     (op_a_q[63] != op_b_q[63]) && (sub_diff[63] != op_a_q[63])};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_flags_q <= 4'b0000;
    end else begin
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_flags = rsp_flags_q;
`else
  logic unused_sub_borrow;

  assign unused_sub_borrow = sub_borrow;
  assign rsp_flags         = 4'b0000;
`endif

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter: directed vector table, burst-order and
// reset corner sequences, and randomized traffic against a behavioural model.

module tb_sub_share_arbiter;

  localparam logic FIRST_PRI = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [63:0] rsp_diff;
  logic [3:0]  rsp_flags;

  logic        b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_busy;
  logic [63:0] b_rsp_diff;
  logic [3:0]  b_rsp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: last winner and its current run of consecutive wins.
  logic m_last;
  int   m_streak;

  always #5 clk = ~clk;

  sub_share_arbiter #(.FIRST_PRI(FIRST_PRI), .BURST_LEN(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_diff(rsp_diff), .rsp_flags(rsp_flags), .busy(busy)
  );

  sub_share_arbiter #(.FIRST_PRI(FIRST_PRI), .BURST_LEN(2)) dut_burst (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id),
    .rsp_diff(b_rsp_diff), .rsp_flags(b_rsp_flags), .busy(b_busy)
  );

  typedef struct packed {
    logic        id;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] diff;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [3:0] modelFlags(input logic [63:0] a, input logic [63:0] b);
`ifdef SUB_ARB_FLAGS_EN
    logic [63:0]        d;
    logic signed [64:0] wide;
    d    = a - b;
    wide = $signed({a[63], a}) - $signed({b[63], b});
    return {d[63], (d == 64'd0), (a >= b), (wide[64] != wide[63])};
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [3:0] tableFlags(input logic [3:0] f);
`ifdef SUB_ARB_FLAGS_EN
    return f;
`else
    return 4'b0000 & f;
`endif
  endfunction

  function automatic logic modelPri();
    if (m_streak != 0 && (m_streak % 1) == 0) return ~m_last;
    return m_last;
  endfunction

  function automatic logic modelWinner(input logic v0, input logic v1);
    if (v0 && v1) return modelPri();
    return v1;
  endfunction

  task automatic modelAccept(input logic g);
    if (g == m_last) m_streak = m_streak + 1;
    else             m_streak = 1;
    m_last = g;
  endtask

  task automatic modelReset();
    m_last   = FIRST_PRI;
    m_streak = 0;
  endtask

  // Under permanent contention each requester wins bl times in a row, FIRST_PRI first.
  function automatic logic burstOrder(input int bl, input int k);
    return FIRST_PRI ^ logic'((k / bl) % 2);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [63:0] a0, input logic [63:0] b0,
                               input logic [63:0] a1, input logic [63:0] b1,
                               input logic rr);
    req0_valid = v0;
    req1_valid = v1;
    req0_a     = a0;
    req0_b     = b0;
    req1_a     = a1;
    req1_b     = b1;
    rsp_ready  = rr;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  // Entered on a negedge with the DUT idle; leaves on a negedge with the DUT idle again.
  task automatic doTransaction(input logic v0, input logic v1,
                               input logic [63:0] a0, input logic [63:0] b0,
                               input logic [63:0] a1, input logic [63:0] b1,
                               input logic exp_id, input logic [63:0] exp_diff,
                               input logic [3:0] exp_flags, input int stall, input string tag);
    applyStimulus(v0, v1, a0, b0, a1, b1, 1'b1);
    #1;
    checkOutput({tag, " grant"}, {62'd0, req1_ready, req0_ready}, exp_id ? 64'd2 : 64'd1);
    @(negedge clk);
    modelAccept(exp_id);
    applyStimulus(1'b0, 1'b0, rnd64(), rnd64(), rnd64(), rnd64(), stall == 0);
    checkOutput({tag, " calc busy"}, {63'd0, busy}, 64'd1);
    checkOutput({tag, " calc rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    checkOutput({tag, " rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
    checkOutput({tag, " rsp_id"}, {63'd0, rsp_id}, {63'd0, exp_id});
    checkOutput({tag, " rsp_diff"}, rsp_diff, exp_diff);
    checkOutput({tag, " rsp_flags"}, {60'd0, rsp_flags}, {60'd0, exp_flags});
    if (stall > 0) applyStimulus(1'b1, 1'b1, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0);
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      checkOutput({tag, " hold rsp"}, {61'd0, rsp_valid, rsp_id, busy}, {61'd0, 1'b1, exp_id, 1'b1});
      checkOutput({tag, " hold diff"}, rsp_diff, exp_diff);
      checkOutput({tag, " hold flags"}, {60'd0, rsp_flags}, {60'd0, exp_flags});
      checkOutput({tag, " hold readies"}, {62'd0, req1_ready, req0_ready}, 64'd0);
      if (s == stall) applyStimulus(1'b0, 1'b0, rnd64(), rnd64(), rnd64(), rnd64(), 1'b1);
    end
    @(negedge clk);
    checkOutput({tag, " back idle"}, {62'd0, busy, rsp_valid}, 64'd0);
  endtask

  logic        qa [$];
  logic        qb [$];
  logic        rv0, rv1, g;
  logic [63:0] ra0, rb0, ra1, rb1;

  initial begin
    vecs[0] = '{id: 1'b0, a: 64'd54, b: 64'd17, diff: 64'd37, flags: 4'b0010};
    vecs[1] = '{id: 1'b1, a: 64'd54, b: 64'hFFFF_FFFF_FFFF_FFEF, diff: 64'd71, flags: 4'b0000};
    vecs[2] = '{id: 1'b0, a: 64'd10, b: 64'd17, diff: 64'hFFFF_FFFF_FFFF_FFF9, flags: 4'b1000};
    vecs[3] = '{id: 1'b0, a: 64'h8000_0000_0000_0000, b: 64'd1,
                diff: 64'h7FFF_FFFF_FFFF_FFFF, flags: 4'b0011};
    vecs[4] = '{id: 1'b1, a: 64'd0, b: 64'd0, diff: 64'd0, flags: 4'b0110};
    vecs[5] = '{id: 1'b1, a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF,
                diff: 64'h8000_0000_0000_0000, flags: 4'b1001};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset outputs", {59'd0, rsp_valid, rsp_id, busy, req1_ready, req0_ready}, 64'd0);
    checkOutput("reset diff", rsp_diff, 64'd0);
    checkOutput("reset flags", {60'd0, rsp_flags}, 64'd0);
    reset = 1'b0;
    modelReset();

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++) begin
      doTransaction(!vecs[i].id, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].a, vecs[i].b,
                    vecs[i].id, vecs[i].diff, tableFlags(vecs[i].flags),
                    (i == 1) ? 5 : 0, $sformatf("vec%0d", i));
    end

    $display("[TB] burst ordering under contention");
    doReset();
    applyStimulus(1'b1, 1'b1, 64'd3, 64'd1, 64'd9, 64'd4, 1'b1);
    #1;
    for (int c = 0; c < 16; c++) begin
      if (req0_ready || req1_ready) qa.push_back(req1_ready);
      if (b_req0_ready || b_req1_ready) qb.push_back(b_req1_ready);
      @(negedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("burst1 grant%0d", k),
                  (k < qa.size()) ? {63'd0, qa[k]} : 64'hDEAD, {63'd0, burstOrder(1, k)});
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("burst2 grant%0d", k),
                  (k < qb.size()) ? {63'd0, qb[k]} : 64'hDEAD, {63'd0, burstOrder(2, k)});
    end
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    repeat (3) @(negedge clk);
    doReset();

    $display("[TB] reset during CALC");
    applyStimulus(1'b0, 1'b1, 64'd0, 64'd0, 64'd100, 64'd1, 1'b1);
    #1;
    checkOutput("rst pending grant", {62'd0, req1_ready, req0_ready}, 64'd2);
    @(negedge clk);
    checkOutput("rst in calc busy", {63'd0, busy}, 64'd1);
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("rst discard", {62'd0, busy, rsp_valid}, 64'd0);
    checkOutput("rst discard diff", rsp_diff, 64'd0);
    @(negedge clk);
    checkOutput("rst no late rsp", {62'd0, busy, rsp_valid}, 64'd0);
    g = modelWinner(1'b1, 1'b1);
    doTransaction(1'b1, 1'b1, 64'd500, 64'd8, 64'd7, 64'd9, g,
                  g ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd492,
                  g ? modelFlags(64'd7, 64'd9) : modelFlags(64'd500, 64'd8), 0, "post-rst");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      ra0 = rnd64();
      rb0 = ($urandom_range(0, 5) == 0) ? ra0 : rnd64();
      ra1 = {32'd0, $urandom()};
      rb1 = ($urandom_range(0, 1) == 0) ? {32'd0, $urandom()} : rnd64();
      g   = modelWinner(rv0, rv1);
      doTransaction(rv0, rv1, ra0, rb0, ra1, rb1, g,
                    g ? (ra1 - rb1) : (ra0 - rb0),
                    g ? modelFlags(ra1, rb1) : modelFlags(ra0, rb0),
                    int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
